// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state encoding and width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of an index/counter able to hold n distinct values, never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority selector: first requester strictly after last, wrapping at PORTS-1.
module rr_priority_select #(
  parameter int PORTS = 4,
  parameter int IW    = uart_tx_arbiter_pkg::idx_w(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    winner,
  output logic             any
);

  logic [IW-1:0] idx;

  // Explicit wrap: PORTS is not necessarily a power of two.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = last;
    for (int k = 0; k < PORTS; k++) begin
      idx = (idx == IW'(PORTS - 1)) ? '0 : idx + IW'(1);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter between AXI-stream
// byte sources; grant held until tlast or a stall timeout, output fully registered.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  input  logic [PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        grant_valid,
  output logic [idx_w(PORTS)-1:0]     grant_index,
  output logic                        timeout_event
);

  localparam int IW = idx_w(PORTS);
  localparam int CW = idx_w(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = (LOCK_TIMEOUT == 0) ? '0 : CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  arb_state_e            state, state_nx;
  logic [IW-1:0]         last_grant;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         winner;
  logic                  any_req;
  logic                  src_xfer, src_last, tmo_hit, release_now;
  logic [DATA_WIDTH-1:0] src_data;

  rr_priority_select #(.PORTS(PORTS), .IW(IW)) u_sel (
    .req    (s_axis_tvalid),
    .last   (last_grant),
    .winner (winner),
    .any    (any_req)
  );

  assign grant_valid = (state == LOCKED);

  // Ready is a function of state and the output register only, never of tvalid.
  always_comb begin
    s_axis_tready = '0;
    if (state == LOCKED)
      s_axis_tready[grant_index] = !m_axis_tvalid || m_axis_tready;
  end

  always_comb begin
    src_xfer = (state == LOCKED) && s_axis_tvalid[grant_index] && s_axis_tready[grant_index];
    src_last = s_axis_tlast[grant_index];
    src_data = s_axis_tdata[int'(grant_index)*DATA_WIDTH +: DATA_WIDTH];
    // tlast release takes precedence: a transfer cycle is never a stall.
    tmo_hit  = (LOCK_TIMEOUT != 0) && (state == LOCKED) && !src_xfer && (cnt == TMO_LAST);
    release_now = (src_xfer && src_last) || tmo_hit;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = LOCKED;
      LOCKED:  if (release_now) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_index   <= '0;
      last_grant    <= IW'(PORTS - 1);
      cnt           <= '0;
      timeout_event <= 1'b0;
    end else begin
      state         <= state_nx;
      timeout_event <= tmo_hit;
      if (state == IDLE) begin
        if (any_req) begin
          grant_index <= winner;
          cnt         <= '0;
        end
      end else begin
        if (src_xfer)            cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        if (release_now)         last_grant <= grant_index;
      end
    end
  end

  // Output stage: reload wins over drain so back-to-back beats flow at full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (src_xfer) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= src_data;
      m_axis_tlast  <= src_last;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
